// File: rtl/bus_slot_arbiter.sv
// Time-slot bus arbiter: splits each CPU cycle into a CPU window and DMA windows
// shared round-robin among N_CH valid/ready channels. Define BUS_SLOT_ARBITER_PRIO_CH0_EN
// to give channel 0 absolute priority.
module bus_slot_arbiter #(
   parameter int unsigned N_CH          = 4,
   parameter int unsigned ADDR_WIDTH    = 17,
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned SLOTS         = 16,
   parameter int unsigned CPU_START     = 8,
   parameter int unsigned ACCESS_CYCLES = 2
) (
   input  logic                         clk_sys_i,
   input  logic                         reset_i,
   input  logic                         cpu_valid_i,
   input  logic [N_CH-1:0]              ch_valid_i,
   input  logic [N_CH-1:0]              ch_rw_ni,
   input  logic [N_CH*ADDR_WIDTH-1:0]   ch_addr_i,
   input  logic [N_CH*DATA_WIDTH-1:0]   ch_data_i,
   output logic [N_CH-1:0]              ch_ready_o,
   output logic [N_CH*DATA_WIDTH-1:0]   ch_data_o,
   input  logic [DATA_WIDTH-1:0]        bus_data_i,
   output logic [ADDR_WIDTH-1:0]        bus_addr_o,
   output logic                         bus_addr_oe,
   output logic [DATA_WIDTH-1:0]        bus_data_o,
   output logic                         bus_data_oe,
   output logic                         bus_rw_no,
   output logic                         ram_oe_o,
   output logic                         ram_we_o,
   output logic                         clk_cpu_o,
   output logic                         cpu_en_o
);

   localparam int unsigned SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
   localparam int unsigned PW = $clog2(ACCESS_CYCLES);
   localparam int unsigned CW = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam logic [SW-1:0] LastSlot  = SW'(SLOTS - 1);
   localparam logic [SW-1:0] CpuStart  = SW'(CPU_START);
   localparam logic [PW-1:0] LastPhase = PW'(ACCESS_CYCLES - 1);

   logic [SW-1:0]              slot_q, slot_d;
   logic [PW-1:0]              phase_q, phase_d;
   logic                       cpu_run_q, cpu_run_d;
   logic                       active_q, active_d;
   logic [CW-1:0]              grant_q, grant_d;
   logic                       rw_q, rw_d;
   logic [CW-1:0]              rr_q, rr_d;
   logic [ADDR_WIDTH-1:0]      bus_addr_q, bus_addr_d;
   logic [DATA_WIDTH-1:0]      bus_data_q, bus_data_d;
   logic                       bus_addr_oe_q, bus_addr_oe_d;
   logic                       bus_data_oe_q, bus_data_oe_d;
   logic                       bus_rw_n_q, bus_rw_n_d;
   logic                       ram_oe_q, ram_oe_d;
   logic                       ram_we_q, ram_we_d;
   logic                       clk_cpu_q, clk_cpu_d;
   logic                       cpu_en_q, cpu_en_d;
   logic [N_CH-1:0]            ch_ready_q, ch_ready_d;
   logic [N_CH*DATA_WIDTH-1:0] ch_data_q, ch_data_d;

   logic                       in_cpu_slot, win_end, win_start, found;
   logic [N_CH-1:0]            elig;
   int unsigned                idx, pick, start, g;

   always_comb begin
      slot_d      = (slot_q == LastSlot) ? '0 : slot_q + SW'(1);
      phase_d     = (slot_d == '0 || phase_q == LastPhase) ? '0 : phase_q + PW'(1);
      cpu_run_d   = (slot_d == '0) ? cpu_valid_i : cpu_run_q;
      in_cpu_slot = (slot_d >= CpuStart);
      clk_cpu_d   = in_cpu_slot;
      cpu_en_d    = in_cpu_slot && cpu_run_d;
      win_end     = active_q && (phase_q == LastPhase);
      win_start   = (phase_d == '0) && !cpu_en_d;

      active_d   = active_q;
      grant_d    = grant_q;
      rw_d       = rw_q;
      rr_d       = rr_q;
      bus_addr_d = bus_addr_q;
      bus_data_d = bus_data_q;
      ch_ready_d = '0;
      ch_data_d  = ch_data_q;
      g          = 32'(grant_q);

      // The channel completing at this edge must sit out the window that starts here.
      elig = ch_valid_i;
      if (win_end) begin
         elig[g]       = 1'b0;
         ch_ready_d[g] = 1'b1;
         if (rw_q) ch_data_d[g*DATA_WIDTH +: DATA_WIDTH] = bus_data_i;
         active_d   = 1'b0;
         bus_addr_d = '0;
         bus_data_d = '0;
      end

      found = 1'b0;
      pick  = 0;
      idx   = 0;
      start = 0;
`ifdef BUS_SLOT_ARBITER_PRIO_CH0_EN
      if (elig[0]) begin
         found = 1'b1;
      end else begin
         start = (rr_q == '0) ? 1 : 32'(rr_q);
         for (int unsigned i = 0; i + 1 < N_CH; i++) begin
            idx = start + i;
            if (idx >= N_CH) idx = idx - N_CH + 1;
            if (!found && elig[idx]) begin
               found = 1'b1;
               pick  = idx;
            end
         end
      end
`else
      start = 32'(rr_q);
      for (int unsigned i = 0; i < N_CH; i++) begin
         idx = start + i;
         if (idx >= N_CH) idx = idx - N_CH;
         if (!found && elig[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
`endif

      if (win_start) begin
         active_d = found;
         if (found) begin
            grant_d    = CW'(pick);
            rw_d       = ch_rw_ni[pick];
            bus_addr_d = ch_addr_i[pick*ADDR_WIDTH +: ADDR_WIDTH];
            bus_data_d = ch_data_i[pick*DATA_WIDTH +: DATA_WIDTH];
`ifdef BUS_SLOT_ARBITER_PRIO_CH0_EN
            // Priority grants to channel 0 leave the rotation untouched.
            if (pick != 0) rr_d = (pick + 1 == N_CH) ? CW'(1) : CW'(pick + 1);
`else
            rr_d = (pick + 1 == N_CH) ? '0 : CW'(pick + 1);
`endif
         end
      end

      bus_addr_oe_d = active_d;
      bus_data_oe_d = active_d && !rw_d;
      bus_rw_n_d    = !(active_d && !rw_d);
      ram_oe_d      = active_d && rw_d;
      ram_we_d      = active_d && !rw_d && (phase_d == LastPhase);
   end

   always_ff @(posedge clk_sys_i or posedge reset_i) begin
      if (reset_i) begin
         slot_q        <= '0;
         phase_q       <= '0;
         cpu_run_q     <= 1'b1;
         active_q      <= 1'b0;
         grant_q       <= '0;
         rw_q          <= 1'b1;
         rr_q          <= '0;
         bus_addr_q    <= '0;
         bus_data_q    <= '0;
         bus_addr_oe_q <= 1'b0;
         bus_data_oe_q <= 1'b0;
         bus_rw_n_q    <= 1'b1;
         ram_oe_q      <= 1'b0;
         ram_we_q      <= 1'b0;
         clk_cpu_q     <= 1'b0;
         cpu_en_q      <= 1'b0;
         ch_ready_q    <= '0;
         ch_data_q     <= '0;
      end else begin
         slot_q        <= slot_d;
         phase_q       <= phase_d;
         cpu_run_q     <= cpu_run_d;
         active_q      <= active_d;
         grant_q       <= grant_d;
         rw_q          <= rw_d;
         rr_q          <= rr_d;
         bus_addr_q    <= bus_addr_d;
         bus_data_q    <= bus_data_d;
         bus_addr_oe_q <= bus_addr_oe_d;
         bus_data_oe_q <= bus_data_oe_d;
         bus_rw_n_q    <= bus_rw_n_d;
         ram_oe_q      <= ram_oe_d;
         ram_we_q      <= ram_we_d;
         clk_cpu_q     <= clk_cpu_d;
         cpu_en_q      <= cpu_en_d;
         ch_ready_q    <= ch_ready_d;
         ch_data_q     <= ch_data_d;
      end
   end

   assign bus_addr_o  = bus_addr_q;
   assign bus_addr_oe = bus_addr_oe_q;
   assign bus_data_o  = bus_data_q;
   assign bus_data_oe = bus_data_oe_q;
   assign bus_rw_no   = bus_rw_n_q;
   assign ram_oe_o    = ram_oe_q;
   assign ram_we_o    = ram_we_q;
   assign clk_cpu_o   = clk_cpu_q;
   assign cpu_en_o    = cpu_en_q;
   assign ch_ready_o  = ch_ready_q;
   assign ch_data_o   = ch_data_q;

endmodule

// File: tb/tb_bus_slot_arbiter.sv
// Bench for bus_slot_arbiter: directed vector table, multi-cycle sequences and a
// randomized run, all checked every cycle against a slot-level reference model.
module tb_bus_slot_arbiter;

   localparam int N = 4, AW = 17, DW = 8, SLOTS = 16, CPU_START = 8, AC = 2;

   logic            clk = 1'b0, rst = 1'b1, cpu_valid = 1'b1;
   logic [N-1:0]    ch_valid = '0, ch_rw = '1, ch_ready_o;
   logic [N*AW-1:0] ch_addr = '0;
   logic [N*DW-1:0] ch_wdata = '0, ch_data_o;
   logic [DW-1:0]   bus_data_i = '0, bus_data_o;
   logic [AW-1:0]   bus_addr_o;
   logic            bus_addr_oe, bus_data_oe, bus_rw_no, ram_oe_o, ram_we_o, clk_cpu_o, cpu_en_o;

   int n_tests = 0, n_fail = 0;

   bus_slot_arbiter #(
      .N_CH(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SLOTS(SLOTS),
      .CPU_START(CPU_START), .ACCESS_CYCLES(AC)
   ) dut (
      .clk_sys_i(clk), .reset_i(rst), .cpu_valid_i(cpu_valid),
      .ch_valid_i(ch_valid), .ch_rw_ni(ch_rw), .ch_addr_i(ch_addr), .ch_data_i(ch_wdata),
      .ch_ready_o(ch_ready_o), .ch_data_o(ch_data_o), .bus_data_i(bus_data_i),
      .bus_addr_o(bus_addr_o), .bus_addr_oe(bus_addr_oe), .bus_data_o(bus_data_o),
      .bus_data_oe(bus_data_oe), .bus_rw_no(bus_rw_no), .ram_oe_o(ram_oe_o),
      .ram_we_o(ram_we_o), .clk_cpu_o(clk_cpu_o), .cpu_en_o(cpu_en_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: whole-window view of the slot schedule.
   int           m_slot, m_gnt, m_rr;
   bit           m_run, m_rw;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic [N-1:0]  m_ready;
   logic [N*DW-1:0] m_chdata;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_slot = 0; m_run = 1; m_gnt = -1; m_rr = 0; m_rw = 1;
         m_ready = '0; m_chdata = '0; m_addr = '0; m_wdata = '0;
      end else begin
         int ns, excl, pick, c;
         ns = (m_slot + 1) % SLOTS;
         excl = -1;
         m_ready = '0;
         if (m_gnt >= 0 && ns % AC == 0) begin
            m_ready[m_gnt] = 1'b1;
            if (m_rw) m_chdata[m_gnt*DW +: DW] = bus_data_i;
            excl = m_gnt;
            m_gnt = -1;
         end
         if (ns == 0) m_run = cpu_valid;
         if (ns % AC == 0 && !(ns >= CPU_START && m_run)) begin
            pick = -1;
`ifdef BUS_SLOT_ARBITER_PRIO_CH0_EN
            if (ch_valid[0] && excl != 0) pick = 0;
            for (int k = 0; k < N - 1; k++) begin
               c = 1 + ((m_rr == 0 ? 0 : m_rr - 1) + k) % (N - 1);
               if (pick < 0 && ch_valid[c] && c != excl) pick = c;
            end
            if (pick > 0) m_rr = (pick + 1 == N) ? 1 : pick + 1;
`else
            for (int k = 0; k < N; k++) begin
               c = (m_rr + k) % N;
               if (pick < 0 && ch_valid[c] && c != excl) pick = c;
            end
            if (pick >= 0) m_rr = (pick + 1) % N;
`endif
            if (pick >= 0) begin
               m_gnt = pick; m_rw = ch_rw[pick];
               m_addr = ch_addr[pick*AW +: AW]; m_wdata = ch_wdata[pick*DW +: DW];
            end
         end
         m_slot = ns;
      end
   end

   always @(negedge clk) begin
      bit g, wr;
      g  = (m_gnt >= 0);
      wr = g && !m_rw;
      check("clk_cpu", clk_cpu_o, m_slot >= CPU_START);
      check("cpu_en", cpu_en_o, m_slot >= CPU_START && m_run);
      check("addr_oe", bus_addr_oe, g);
      check("ram_oe", ram_oe_o, g && m_rw);
      check("data_oe", bus_data_oe, wr);
      check("rw_n", bus_rw_no, !wr);
      check("ram_we", ram_we_o, wr && (m_slot % AC == AC - 1));
      check("ready", ch_ready_o, m_ready);
      check("ch_data", ch_data_o, m_chdata);
      if (g) check("bus_addr", bus_addr_o, m_addr);
      if (wr) check("bus_wdata", bus_data_o, m_wdata);
   end

   typedef struct {
      int          ch;
      logic        rw;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] rdata;
      logic [N-1:0]  exp_ready;
      int          exp_we;
      int          exp_oe;
   } vec_t;

   vec_t vecs[5];

   task automatic pulse_reset();
      @(negedge clk); #2 rst = 1'b1;
      @(negedge clk); @(negedge clk); #2 rst = 1'b0;
   endtask

   task automatic new_req(input int c);
      ch_rw[c] = 1'($urandom);
      ch_addr[c*AW +: AW] = AW'($urandom);
      ch_wdata[c*DW +: DW] = DW'($urandom);
   endtask

   initial begin
      logic [31:0] act_clk, exp_clk, act_en, exp_en;
      logic [15:0] pat, exp_pat;
      logic [DW-1:0] last0;
      int oe_seen, cnt, n_rdy, en_cnt;
      int order[$];

      vecs[0] = '{0, 1'b1, 17'h00100, 8'h00, 8'h3C, 4'b0001, 0, 2};
      vecs[1] = '{1, 1'b0, 17'h1E800, 8'hA5, 8'h00, 4'b0010, 1, 0};
      vecs[2] = '{2, 1'b1, 17'h0ABCD, 8'h00, 8'h5A, 4'b0100, 0, 2};
      vecs[3] = '{3, 1'b0, 17'h1FFFF, 8'h00, 8'h77, 4'b1000, 1, 0};
      vecs[4] = '{0, 1'b1, 17'h00000, 8'h00, 8'hC3, 4'b0001, 0, 2};

      // Reset values and the idle CPU-running schedule.
      repeat (3) @(negedge clk);
      check("rst_rw_n", bus_rw_no, 1'b1);
      check("rst_clk_cpu", clk_cpu_o, 1'b0);
      #2 rst = 1'b0;
      oe_seen = 0;
      for (int k = 1; k <= 32; k++) begin
         @(negedge clk);
         act_clk[k-1] = clk_cpu_o; exp_clk[k-1] = (k % 16) >= 8;
         act_en[k-1]  = cpu_en_o;  exp_en[k-1]  = (k % 16) >= 8;
         if (bus_addr_oe) oe_seen++;
      end
      check("idle_clk_cpu_pattern", act_clk, exp_clk);
      check("idle_cpu_en_pattern", act_en, exp_en);
      check("idle_no_addr_oe", oe_seen, 0);

      // Single-channel transactions from the vector table.
      last0 = '0;
      foreach (vecs[i]) begin
         int we_c, oe_c, rwlo_c;
         logic [N-1:0] rdy;
         logic [AW-1:0] sa;
         logic [DW-1:0] sd;
         bit done;
         we_c = 0; oe_c = 0; rwlo_c = 0; rdy = '0; sa = '0; sd = '0; done = 0;
         bus_data_i = vecs[i].rdata;
         ch_rw[vecs[i].ch] = vecs[i].rw;
         ch_addr[vecs[i].ch*AW +: AW] = vecs[i].addr;
         ch_wdata[vecs[i].ch*DW +: DW] = vecs[i].wdata;
         ch_valid[vecs[i].ch] = 1'b1;
         for (int k = 0; k < 64 && !done; k++) begin
            @(negedge clk);
            if (bus_addr_oe) sa = bus_addr_o;
            if (bus_data_oe) sd = bus_data_o;
            if (ram_we_o) we_c++;
            if (ram_oe_o) oe_c++;
            if (!bus_rw_no) rwlo_c++;
            if (ch_ready_o != '0) begin rdy = ch_ready_o; done = 1; end
         end
         ch_valid[vecs[i].ch] = 1'b0;
         check("vec_done", done, 1'b1);
         check("vec_ready", rdy, vecs[i].exp_ready);
         check("vec_addr", sa, vecs[i].addr);
         check("vec_we_cnt", we_c, vecs[i].exp_we);
         check("vec_oe_cnt", oe_c, vecs[i].exp_oe);
         check("vec_rw_low_cnt", rwlo_c, vecs[i].rw ? 0 : AC);
         if (!vecs[i].rw) check("vec_wdata", sd, vecs[i].wdata);
         if (vecs[i].rw) check("vec_rdata", ch_data_o[vecs[i].ch*DW +: DW], vecs[i].rdata);
         if (vecs[i].rw && vecs[i].ch == 0) last0 = vecs[i].rdata;
         check("ch0_data_held", ch_data_o[DW-1:0], last0);
         @(negedge clk);
      end

      // All channels busy from reset: strict rotation, three then four per cycle.
      for (int c = 0; c < N; c++) begin
         ch_rw[c] = 1'b1; ch_addr[c*AW +: AW] = AW'(c); ch_valid[c] = 1'b1;
      end
      pulse_reset();
      for (int k = 1; k <= 32; k++) begin
         @(negedge clk);
         for (int c = 0; c < N; c++) if (ch_ready_o[c]) order.push_back(c);
      end
      check("rr_count", order.size(), 7);
      for (int j = 0; j < 7 && j < order.size(); j++) check("rr_order", order[j], j % N);

      // CPU halted: the CPU window turns into DMA windows.
      cpu_valid = 1'b0;
      cnt = 0;
      while (m_slot != 15 && cnt < 40) begin @(negedge clk); cnt++; end
      @(negedge clk);
      n_rdy = 0; en_cnt = 0;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         for (int c = 0; c < N; c++) if (ch_ready_o[c]) n_rdy++;
         if (cpu_en_o) en_cnt++;
         pat[k] = clk_cpu_o; exp_pat[k] = ((k + 1) % 16) >= 8;
      end
      check("halt_windows", n_rdy, 8);
      check("halt_cpu_en", en_cnt, 0);
      check("halt_clk_cpu", pat, exp_pat);
      cpu_valid = 1'b1;
      ch_valid = '0;

      // Reset landing in the first clock of a write window.
      @(negedge clk);
      ch_rw[1] = 1'b0; ch_addr[AW +: AW] = 17'h1E800; ch_wdata[DW +: DW] = 8'hA5;
      ch_valid[1] = 1'b1;
      cnt = 0;
      do begin @(negedge clk); cnt++; end while (!(bus_data_oe && !ram_we_o) && cnt < 64);
      check("rstwin_found", bus_data_oe, 1'b1);
      #2 rst = 1'b1;
      #1;
      check("rstwin_we", ram_we_o, 1'b0);
      check("rstwin_addr_oe", bus_addr_oe, 1'b0);
      check("rstwin_data_oe", bus_data_oe, 1'b0);
      check("rstwin_rw_n", bus_rw_no, 1'b1);
      check("rstwin_ready", ch_ready_o, '0);
      check("rstwin_ch_data", ch_data_o, '0);
      ch_valid = '0;
      repeat (2) begin
         @(negedge clk);
         check("rstwin_hold_we", ram_we_o, 1'b0);
         check("rstwin_hold_ready", ch_ready_o, '0);
      end
      #2 rst = 1'b0;

      // Randomized traffic; the per-cycle model comparison does the checking.
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         cpu_valid = ($urandom % 4) != 0;
         bus_data_i = DW'($urandom);
         for (int c = 0; c < N; c++) begin
            if (ch_valid[c]) begin
               if (ch_ready_o[c]) begin
                  if ($urandom % 2 == 0) ch_valid[c] = 1'b0;
                  else new_req(c);
               end
            end else if ($urandom % 3 == 0) begin
               new_req(c);
               ch_valid[c] = 1'b1;
            end
         end
      end

      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule

// File: doc/bus_slot_arbiter.md
Name: bus_slot_arbiter

Overview:
- Parametrised successor to the fixed SPI/CPU time-slot scheme.
- Divides each CPU cycle into a CPU window and a number of DMA access windows.
- Grants the DMA windows among N_CH requestor channels, e.g. SPI bridge, video fetch, audio, debug. Each channel uses a valid/ready handshake.
- Drives the shared system address/data bus, the RAM strobes, clk_cpu_o and cpu_en_o. The top level muxes chip selects from these.

Parameters:
- N_CH, 4, number of requestor channels (1..8).
- ADDR_WIDTH, 17, system bus address width.
- DATA_WIDTH, 8, system bus data width.
- SLOTS, 16, clk_sys_i periods per CPU cycle (16 MHz / 16 = 1 MHz).
- CPU_START, 8, first slot of the CPU window. CPU_START % ACCESS_CYCLES must be 0.
- ACCESS_CYCLES, 2, clocks per DMA window (2..4).

Ports:
- clk_sys_i  in  1  system clock, 16 MHz
- reset_i  in  1  asynchronous, active-high reset
- cpu_valid_i  in  1  1 = CPU runs; 0 = CPU halted
- ch_valid_i  in  N_CH  request pending, per channel
- ch_rw_ni  in  N_CH  1 = read, 0 = write, per channel
- ch_addr_i  in  N_CH*ADDR_WIDTH  packed request addresses, channel 0 in the LSBs
- ch_data_i  in  N_CH*DATA_WIDTH  packed write data
- ch_ready_o  out  N_CH  one-clock completion pulse
- ch_data_o  out  N_CH*DATA_WIDTH  packed read data, held until the next read by that channel completes
- bus_data_i  in  DATA_WIDTH  system data bus in
- bus_addr_o  out  ADDR_WIDTH  address driven during a DMA window
- bus_addr_oe  out  1  drive enable for bus_addr_o
- bus_data_o  out  DATA_WIDTH  write data
- bus_data_oe  out  1  drive enable for bus_data_o
- bus_rw_no  out  1  0 only during a granted write window
- ram_oe_o  out  1  RAM output enable (active-high)
- ram_we_o  out  1  RAM write strobe (active-high)
- clk_cpu_o  out  1  CPU clock
- cpu_en_o  out  1  CPU owns the bus

Behaviour:
- Slot counter: counts 0..SLOTS-1 and wraps. Reset value 0.
- clk_cpu_o: registered; high while slot is in CPU_START..SLOTS-1.
- cpu_valid_i sampling: sampled at the edge entering slot 0 and held for the whole CPU cycle.
- CPU window:
  - If the sampled value is 1, cpu_en_o is high for slots CPU_START..SLOTS-1 and no DMA grant is made there.
  - If the sampled value is 0, cpu_en_o stays 0 and the CPU window is split into further DMA windows. This gives SLOTS/ACCESS_CYCLES windows per cycle.
- DMA windows: start at slots that are multiples of ACCESS_CYCLES inside the available region.
- Arbitration: happens at the edge starting each window.
  - Round-robin from pointer rr, over channels with ch_valid_i=1, excluding any channel that completed at this same edge.
  - On a grant, rr becomes grant+1 modulo N_CH.
  - No pending channel means an idle window: all enables stay 0.
- Granted window outputs (all registered):
  - bus_addr_oe=1; bus_addr_o = the granted channel's address.
  - For a read, ram_oe_o=1 for the whole window.
  - For a write, bus_rw_no=0 and bus_data_oe=1 for the whole window, with bus_data_o = the channel's write data. ram_we_o=1 only in the final clock of the window.
- Completion: at the edge ending the window:
  - ch_ready_o[g] pulses high for exactly one clock.
  - For a read, bus_data_i is captured into ch_data_o[g] at that edge.
- Handshake rules: the requester holds valid, rw, addr and data stable until it sees ready. A channel drops valid for one cycle or presents its next request. A completing channel is never granted the immediately following window.
- Idle values: all bus enables 0, bus_rw_no=1, ram strobes 0.
- Reset values: slot 0, rr 0, clk_cpu_o 0, cpu_en_o 0, every enable 0, bus_rw_no=1, ch_ready_o 0, ch_data_o 0.
- Reset mid-window: the access is abandoned. No ram_we_o and no ready pulse.
- ch_valid_i dropped mid-window (protocol violation): the access still completes and ready still pulses.

Optional Feature:
- Macro: BUS_SLOT_ARBITER_PRIO_CH0_EN.
- Defined: channel 0 (video fetch) wins every window in which it is eligible. Channels 1..N_CH-1 round-robin among the remaining windows, and rr skips channel 0.
- Undefined: pure round-robin over all channels.

Test Plan:
- Reset release, cpu_valid_i=1, no requests: clk_cpu_o period 16 clocks, high in slots 8-15; cpu_en_o high in slots 8-15; bus_addr_oe never 1.
- ch1 writes 0x1E800 with data 0xA5: next DMA window drives bus_addr_o=0x1E800, bus_data_o=0xA5, bus_rw_no=0; ram_we_o high for 1 clock (second clock of the window); ch_ready_o=4'b0010 for 1 clock.
- ch0 reads with bus_data_i=0x3C: ram_oe_o high for 2 clocks; at ready, ch_data_o[7:0]=0x3C, held until ch0's next read.
- All 4 channels continuously valid, cpu_valid_i=1: grant order 0,1,2,3,0,… with 4 windows per CPU cycle; each channel completes once per CPU cycle.
- cpu_valid_i=0 from slot 0: 8 DMA windows in that cycle; cpu_en_o stays 0; clk_cpu_o keeps toggling.
- reset_i asserted in the first clock of a write window: ram_we_o never asserts, ch_ready_o stays 0, all outputs at reset values immediately.
